// File: rtl/fp32_pkg.sv
// FP32 field constants and extract helpers shared by the multiplier and adder pipelines.
package fp32_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam int FP_BIAS   = 127;
    localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

    localparam int FP_SIG_W  = FP_FRAC_W + 1;
    localparam int FP_PROD_W = 2 * FP_SIG_W;
    // Wide enough that tiny exponent sums go negative instead of wrapping.
    localparam int FP_E_W    = 10;

    typedef struct packed {
        logic                     s;
        logic signed [FP_E_W-1:0] e;
        logic                     is_zero;
        logic                     is_inf;
    } fp_mul_ctl_t;

    function automatic logic fp_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [FP_EXP_W-1:0] fp_exp(input logic [31:0] x);
        return x[30:FP_FRAC_W];
    endfunction

    function automatic logic [FP_SIG_W-1:0] fp_sig(input logic [31:0] x);
        return {1'b1, x[FP_FRAC_W-1:0]};
    endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Normalize / round / exception-pack back end of the FP32 multiplier (two registered stages).
module fp_mul_round
    import fp32_pkg::*;
#(
    parameter bit ROUND_EN = 1'b1
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 valid_i,
    input  fp_mul_ctl_t          ctl_i,
    input  logic [FP_PROD_W-1:0] prod_i,
    output logic                 valid_o,
    output logic [31:0]          result_o,
    output logic                 ovf_o,
    output logic                 unf_o,
    output logic                 zero_o
);

    logic                  s3_valid_q;
    fp_mul_ctl_t           s3_ctl_q, s3_ctl_d;
    logic [FP_SIG_W-1:0]   s3_m_q, s3_m_d;
    logic                  s3_r_q, s3_r_d;

    logic                  out_valid_q;
    logic [31:0]           result_q, result_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  zero_q, zero_d;

    logic [FP_SIG_W:0]        m_rnd;
    logic [FP_FRAC_W-1:0]     frac;
    logic signed [FP_E_W-1:0] e_fin;

    always_comb begin
        s3_ctl_d = ctl_i;
        s3_m_d   = prod_i[FP_PROD_W-2:FP_SIG_W-1];
        s3_r_d   = prod_i[FP_SIG_W-2];
        if (prod_i[FP_PROD_W-1]) begin
            s3_m_d     = prod_i[FP_PROD_W-1:FP_SIG_W];
            s3_r_d     = prod_i[FP_SIG_W-1];
            s3_ctl_d.e = ctl_i.e + 10'sd1;
        end
    end

    always_comb begin
        m_rnd    = {1'b0, s3_m_q} + (FP_SIG_W+1)'(ROUND_EN & s3_r_q);
        frac     = m_rnd[FP_FRAC_W-1:0];
        e_fin    = s3_ctl_q.e;
        // Rounding all-ones up carries into a new leading bit: 1.111.. -> 10.000..
        if (m_rnd[FP_SIG_W]) begin
            frac  = '0;
            e_fin = s3_ctl_q.e + 10'sd1;
        end

        result_d = {s3_ctl_q.s, e_fin[FP_EXP_W-1:0], frac};
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        zero_d   = 1'b0;
        if (s3_ctl_q.is_zero) begin
            result_d = {s3_ctl_q.s, 31'h0};
            zero_d   = 1'b1;
        end else if (s3_ctl_q.is_inf || e_fin >= 10'sd255) begin
            result_d = {s3_ctl_q.s, FP_EXP_MAX, {FP_FRAC_W{1'b0}}};
            ovf_d    = 1'b1;
        end else if (e_fin <= 10'sd0) begin
            result_d = {s3_ctl_q.s, 31'h0};
            unf_d    = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s3_valid_q  <= 1'b0;
            s3_ctl_q    <= '0;
            s3_m_q      <= '0;
            s3_r_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            s3_valid_q  <= valid_i;
            s3_ctl_q    <= s3_ctl_d;
            s3_m_q      <= s3_m_d;
            s3_r_q      <= s3_r_d;
            out_valid_q <= s3_valid_q;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            zero_q      <= zero_d;
        end
    end

    assign valid_o  = out_valid_q;
    assign result_o = result_q;
    assign ovf_o    = ovf_q;
    assign unf_o    = unf_q;
    assign zero_o   = zero_q;

endmodule

// File: rtl/float_multiplier.sv
// Four-stage FP32 multiplier: unpack, 24x24 multiply, then normalize/round/pack in fp_mul_round.
module float_multiplier
    import fp32_pkg::*;
#(
    parameter int EXP_BIAS = FP_BIAS,
    parameter bit ROUND_EN = 1'b1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    output logic [31:0] result,
    output logic        ovf,
    output logic        unf,
    output logic        zero
);

    localparam logic [FP_E_W-1:0] BIAS_E = FP_E_W'(EXP_BIAS);

    logic                 s1_valid_q;
    fp_mul_ctl_t          s1_ctl_q, s1_ctl_d;
    logic [FP_SIG_W-1:0]  s1_sig_a_q, s1_sig_b_q;

    logic                 s2_valid_q;
    fp_mul_ctl_t          s2_ctl_q;
    logic [FP_PROD_W-1:0] s2_prod_q;

    logic [FP_EXP_W-1:0]  exp_a, exp_b;

    assign exp_a = fp_exp(A);
    assign exp_b = fp_exp(B);

    always_comb begin
        s1_ctl_d.s       = fp_sign(A) ^ fp_sign(B);
        s1_ctl_d.e       = {2'b00, exp_a} + {2'b00, exp_b} - BIAS_E;
        s1_ctl_d.is_zero = (exp_a == '0) || (exp_b == '0);
        s1_ctl_d.is_inf  = (exp_a == FP_EXP_MAX) || (exp_b == FP_EXP_MAX);
    end

    // Data registers load every cycle; only the valid bits are meaningful qualifiers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s1_ctl_q   <= '0;
            s1_sig_a_q <= '0;
            s1_sig_b_q <= '0;
            s2_valid_q <= 1'b0;
            s2_ctl_q   <= '0;
            s2_prod_q  <= '0;
        end else begin
            s1_valid_q <= in_valid;
            s1_ctl_q   <= s1_ctl_d;
            s1_sig_a_q <= fp_sig(A);
            s1_sig_b_q <= fp_sig(B);
            s2_valid_q <= s1_valid_q;
            s2_ctl_q   <= s1_ctl_q;
            s2_prod_q  <= {{FP_SIG_W{1'b0}}, s1_sig_a_q} * {{FP_SIG_W{1'b0}}, s1_sig_b_q};
        end
    end

    fp_mul_round #(
        .ROUND_EN (ROUND_EN)
    ) u_round (
        .clock    (clock),
        .resetn   (resetn),
        .valid_i  (s2_valid_q),
        .ctl_i    (s2_ctl_q),
        .prod_i   (s2_prod_q),
        .valid_o  (out_valid),
        .result_o (result),
        .ovf_o    (ovf),
        .unf_o    (unf),
        .zero_o   (zero)
    );

endmodule

// File: tb/tb_float_multiplier.sv
// Self-checking bench for float_multiplier: directed vector table, back-to-back and reset sequences, random stream vs integer model.
module tb_float_multiplier;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        zero;
    } res_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        res_t        r1;
        res_t        r0;
    } vec_t;

    typedef struct packed {
        logic v;
        res_t r1;
        res_t r0;
    } stage_t;

    logic        clock;
    logic        resetn;
    logic        in_valid;
    logic [31:0] A, B;
    logic        ov1, ovf1, unf1, zero1;
    logic [31:0] res1;
    logic        ov0, ovf0, unf0, zero0;
    logic [31:0] res0;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    stage_t pipe [4];
    vec_t   vecs [10];

    float_multiplier #(.EXP_BIAS(127), .ROUND_EN(1'b1)) dut_rnd (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .A(A), .B(B),
        .out_valid(ov1), .result(res1), .ovf(ovf1), .unf(unf1), .zero(zero1)
    );

    float_multiplier #(.EXP_BIAS(127), .ROUND_EN(1'b0)) dut_trn (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .A(A), .B(B),
        .out_valid(ov0), .result(res0), .ovf(ovf0), .unf(unf0), .zero(zero0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: exact integer product of significands, then the half-up / truncate rules.
    function automatic res_t ref_mul(input logic [31:0] a, input logic [31:0] b, input bit rnd);
        res_t o;
        int ea, eb, e, sh;
        longint unsigned ma, mb, prod, mant;
        logic s;
        o  = '0;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 0 || eb == 0) begin
            o.res = {s, 31'h0};
            o.zero = 1'b1;
            return o;
        end
        if (ea == 255 || eb == 255) begin
            o.res = {s, 8'hFF, 23'h0};
            o.ovf = 1'b1;
            return o;
        end
        ma   = (64'd1 << 23) | 64'(a[22:0]);
        mb   = (64'd1 << 23) | 64'(b[22:0]);
        prod = ma * mb;
        e    = ea + eb - 127;
        if (prod >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        mant = prod >> sh;
        if (rnd && (((prod >> (sh - 1)) & 64'd1) != 0)) mant = mant + 1;
        if (mant == (64'd1 << 24)) begin
            mant = 64'd1 << 23;
            e    = e + 1;
        end
        if (e >= 255) begin
            o.res = {s, 8'hFF, 23'h0};
            o.ovf = 1'b1;
        end else if (e <= 0) begin
            o.res = {s, 31'h0};
            o.unf = 1'b1;
        end else begin
            o.res = {s, 8'(e), 23'(mant)};
        end
        return o;
    endfunction

    task automatic check_res(input string tag, input res_t act, input res_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got res=%h ovf=%b unf=%b zero=%b, expected res=%h ovf=%b unf=%b zero=%b",
                     tag, act.res, act.ovf, act.unf, act.zero, exp.res, exp.ovf, exp.unf, exp.zero);
        end
    endtask

    task automatic check_bit(input string tag, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", tag, act, exp);
        end
    endtask

    function automatic res_t mk(input logic [31:0] r, input logic o, input logic u, input logic z);
        res_t x;
        x.res = r; x.ovf = o; x.unf = u; x.zero = z;
        return x;
    endfunction

    // Latency model: expected outputs shift through four slots.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {in_valid, ref_mul(A, B, 1'b1), ref_mul(A, B, 1'b0)};
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
    end

    always @(negedge clock) begin
        if (mon_en) begin
            check_bit("mon_valid_rnd", ov1, pipe[3].v);
            check_bit("mon_valid_trn", ov0, pipe[3].v);
            if (pipe[3].v) begin
                check_res("mon_res_rnd", mk(res1, ovf1, unf1, zero1), pipe[3].r1);
                check_res("mon_res_trn", mk(res0, ovf0, unf0, zero0), pipe[3].r0);
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b);
        A = a;
        B = b;
        in_valid = 1'b1;
    endtask

    initial begin
        int stale;
        vecs[0] = {32'h3FC00000, 32'h40000000, mk(32'h40400000,0,0,0), mk(32'h40400000,0,0,0)};
        vecs[1] = {32'hBFC00000, 32'h40000000, mk(32'hC0400000,0,0,0), mk(32'hC0400000,0,0,0)};
        vecs[2] = {32'h3FC00000, 32'h3FC00000, mk(32'h40100000,0,0,0), mk(32'h40100000,0,0,0)};
        vecs[3] = {32'h3F800001, 32'h3FC00000, mk(32'h3FC00002,0,0,0), mk(32'h3FC00001,0,0,0)};
        vecs[4] = {32'h7F000000, 32'h40000000, mk(32'h7F800000,1,0,0), mk(32'h7F800000,1,0,0)};
        vecs[5] = {32'h00800000, 32'h3F000000, mk(32'h00000000,0,1,0), mk(32'h00000000,0,1,0)};
        vecs[6] = {32'h00000000, 32'hC0400000, mk(32'h80000000,0,0,1), mk(32'h80000000,0,0,1)};
        vecs[7] = {32'h7F800000, 32'h00000000, mk(32'h00000000,0,0,1), mk(32'h00000000,0,0,1)};
        // Significand product is 2^47-1: the round carry lifts e from 254 to 255.
        vecs[8] = {32'h7F21E58F, 32'h3FCA6691, mk(32'h7F800000,1,0,0), mk(32'h7F7FFFFF,0,0,0)};
        vecs[9] = {32'h00800000, 32'h00800000, mk(32'h00000000,0,1,0), mk(32'h00000000,0,1,0)};

        resetn = 1'b0;
        in_valid = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(negedge clock);
        check_res("reset_state_rnd", mk(res1, ovf1, unf1, zero1), '0);
        check_bit("reset_valid_rnd", ov1, 1'b0);
        check_bit("reset_valid_trn", ov0, 1'b0);
        resetn = 1'b1;
        @(negedge clock);
        mon_en = 1'b1;

        // Back-to-back pair: results on consecutive cycles, exactly four after issue.
        @(negedge clock); drive(32'h3FC00000, 32'h40000000);
        @(negedge clock); drive(32'hBFC00000, 32'h40000000);
        @(negedge clock); in_valid = 1'b0;
        @(negedge clock); check_bit("b2b_early", ov1, 1'b0);
        @(negedge clock); check_bit("b2b_v0", ov1, 1'b1);
        check_res("b2b_r0", mk(res1, ovf1, unf1, zero1), mk(32'h40400000,0,0,0));
        @(negedge clock); check_bit("b2b_v1", ov1, 1'b1);
        check_res("b2b_r1", mk(res1, ovf1, unf1, zero1), mk(32'hC0400000,0,0,0));
        @(negedge clock); check_bit("b2b_after", ov1, 1'b0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clock); drive(vecs[i].a, vecs[i].b);
            @(negedge clock); in_valid = 1'b0;
            repeat (2) @(negedge clock);
            check_bit($sformatf("vec%0d_early", i), ov1, 1'b0);
            @(negedge clock);
            check_bit($sformatf("vec%0d_valid", i), ov1, 1'b1);
            check_res($sformatf("vec%0d_rnd", i), mk(res1, ovf1, unf1, zero1), vecs[i].r1);
            check_res($sformatf("vec%0d_trn", i), mk(res0, ovf0, unf0, zero0), vecs[i].r0);
        end

        repeat (2) @(negedge clock);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            drive({1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)},
                  {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)});
        end
        @(negedge clock);
        in_valid = 1'b0;
        check_bit("pre_reset_valid", ov1, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check_bit("async_clear_valid", ov1, 1'b0);
        check_res("async_clear_res", mk(res1, ovf1, unf1, zero1), '0);
        check_res("async_clear_res_trn", mk(res0, ovf0, unf0, zero0), '0);
        @(negedge clock);
        resetn = 1'b1;
        stale = 0;
        repeat (8) begin
            @(negedge clock);
            if (ov1 || ov0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL stale_after_reset: got %0d out_valid cycles, expected 0", stale);
        end

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
